// File: rtl/game_sequencer_if.sv
// Signal bundle between the Mastermind game sequencer and its surroundings:
// button/mode/scoring inputs plus the decoded control and status outputs.
interface game_sequencer_if;
    logic       tick;
    logic       select;
    logic       mode;
    logic       score_done;
    logic [2:0] exact;
    logic       hist_clear;
    logic       code_latch;
    logic       commit;
    logic       score_start;
    logic       guess_enable;
    logic [2:0] turn;
    logic       win;
    logic       lose;
    logic [2:0] state;

    modport master (
        output tick, select, mode, score_done, exact,
        input  hist_clear, code_latch, commit, score_start, guess_enable,
        input  turn, win, lose, state
    );

    modport slave (
        input  tick, select, mode, score_done, exact,
        output hist_clear, code_latch, commit, score_start, guess_enable,
        output turn, win, lose, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Moore FSM that runs one Mastermind game: clear, new code, guess/commit/score
// loop, then a held win/lose result before automatically restarting.
module game_sequencer #(
    parameter int unsigned MAX_TURNS  = 8,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_NEWCODE = 3'd1,
        S_GUESS   = 3'd2,
        S_COMMIT  = 3'd3,
        S_SCORE   = 3'd4,
        S_CHECK   = 3'd5,
        S_WIN     = 3'd6,
        S_LOSE    = 3'd7
    } state_t;

    localparam logic [2:0] LAST_TURN = 3'(MAX_TURNS - 1);
    localparam logic [3:0] HOLD_LIM  = 4'(HOLD_TICKS);

    state_t     state_q, state_d;
    logic [2:0] turn_q, turn_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] exact_q, exact_d;
    logic       sel_q;
    logic       sel_edge;
    logic       hist_clear_q, code_latch_q, commit_q, score_start_q, win_q, lose_q;

    assign sel_edge = bus.select & ~sel_q;

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        exact_d = exact_q;
        case (state_q)
            S_CLEAR: begin
                state_d = S_NEWCODE;
                turn_d  = '0;
            end
            S_NEWCODE: state_d = S_GUESS;
            S_GUESS: begin
                if (sel_edge && !bus.mode) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_SCORE;
            S_SCORE: begin
                // score_start_q marks the first SCORE cycle, where score_done is not accepted
                if (bus.score_done && !score_start_q) begin
                    exact_d = bus.exact;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (exact_q[2]) begin
                    state_d = S_WIN;
                    hold_d  = '0;
                end else if (turn_q == LAST_TURN) begin
                    state_d = S_LOSE;
                    hold_d  = '0;
                end else begin
                    turn_d  = turn_q + 3'd1;
                    state_d = S_GUESS;
                end
            end
            S_WIN, S_LOSE: begin
                if (sel_edge || hold_q == HOLD_LIM) state_d = S_CLEAR;
                else if (bus.tick) hold_d = hold_q + 4'd1;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Pulse outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            turn_q        <= '0;
            hold_q        <= '0;
            exact_q       <= '0;
            sel_q         <= 1'b1;
            hist_clear_q  <= 1'b1;
            code_latch_q  <= 1'b0;
            commit_q      <= 1'b0;
            score_start_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            turn_q        <= turn_d;
            hold_q        <= hold_d;
            exact_q       <= exact_d;
            sel_q         <= bus.select;
            hist_clear_q  <= (state_d == S_CLEAR);
            code_latch_q  <= (state_d == S_NEWCODE);
            commit_q      <= (state_d == S_COMMIT);
            score_start_q <= (state_d == S_SCORE) && (state_q != S_SCORE);
            win_q         <= (state_d == S_WIN);
            lose_q        <= (state_d == S_LOSE);
        end
    end

    assign bus.hist_clear   = hist_clear_q;
    assign bus.code_latch   = code_latch_q;
    assign bus.commit       = commit_q;
    assign bus.score_start  = score_start_q;
    assign bus.guess_enable = (state_q == S_GUESS) && !bus.mode;
    assign bus.turn         = turn_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
    assign bus.state        = state_q;
endmodule
